mt_fsm: RTL and testbench
=========================

// Module: mt_fsm
// PURPOSE
//   MT19937 (32-bit Mersenne Twister) pseudo-random number generator.
//   Sequenced by an internal FSM: seed load, state initialisation, then continuous twist+temper.
//   After initialisation it emits one tempered 32-bit word per clock, flagged by valid_rn.
//   Free-running source block for stimulus/Monte-Carlo logic; no downstream backpressure.
// PARAMETERS
//   DEFAULT_SEED  32'd5489  seed used when no external seed is supplied after reset
// PORTS
//   clk                  in   1   system clock, rising edge
//   rst                  in   1   asynchronous, active-low reset
//   external_seed_enable in   1   high: load/hold external_seed_value as seed; low: run
//   external_seed_value  in   32  seed value, sampled while external_seed_enable=1
//   random_number        out  32  tempered MT19937 output word (registered)
//   valid_rn             out  1   random_number holds a new word this cycle (registered)
// BEHAVIOUR
//   State store: mt[0..623], 32-bit each (register file or RAM); index i: 10 bits.
//   Reset (rst=0, async): FSM=LOAD, seed_reg=DEFAULT_SEED, i=0, random_number=0, valid_rn=0.
//   FSM states and transitions:
//   - LOAD: if external_seed_enable=1, seed_reg<=external_seed_value, stay.
//     If external_seed_enable=0, go to INIT.
//   - INIT: cycle 0 writes mt[0]=seed_reg.
//     Then 1 word per cycle: mt[i]=1812433253*(mt[i-1]^(mt[i-1]>>30))+i, for i=1..623.
//     Multiply is mod 2^32. Takes 624 cycles, then go to TWIST with i=0.
//   - TWIST: one index per cycle, in place:
//     y = (mt[i]&32'h80000000)|(mt[(i+1)%624]&32'h7FFFFFFF).
//     mt[i] <= mt[(i+397)%624] ^ (y>>1) ^ (y[0] ? 32'h9908B0DF : 0).
//     Reads use current array contents, so wrapped indices see already-updated words (standard MT).
//     Temper the new word t:
//       t^=t>>11; t^=(t<<7)&32'h9D2C5680; t^=(t<<15)&32'hEFC60000; t^=t>>18.
//     Register the result into random_number with valid_rn=1 on the same clock edge that writes mt[i].
//     i wraps 623->0 with no gap, so valid_rn stays high every cycle indefinitely.
//   Latency: first valid_rn=1 occurs on the 625th clock edge after LOAD exits.
//     That is 624 INIT cycles plus 1 TWIST cycle.
//   valid_rn=0 in LOAD and INIT. random_number holds its last value whenever valid_rn=0.
//   external_seed_enable=1 during INIT or TWIST aborts the sequence:
//     next edge: FSM=LOAD, valid_rn=0, seed_reg<=external_seed_value.
//     Full re-initialisation on release; no partial-state reuse.
//   Reset mid-operation: immediate async return to reset values.
//     Array contents need not be cleared; the INIT pass rewrites them all.
//   Output sequence is bit-exact with reference MT19937 genrand_int32 for the same seed.
// TESTING
//   1. Reset, enable=0 (seed 5489) -> first three valid words 3499211612, 581869302, 3890346734.
//   2. Same as 1 -> 10000th valid word = 4123659995; valid_rn never drops across 624-word wraps.
//   3. enable=1, value=32'hFEEDBEEF for 2 cycles after reset, then 0
//      -> output matches C MT19937 init_genrand(0xFEEDBEEF) for 1,000,000 words.
//   4. Count cycles from enable falling to first valid_rn -> exactly 625 edges.
//      Check random_number=0 and valid_rn=0 until then.
//   5. Assert enable mid-TWIST with seed 5489 -> valid_rn=0 next cycle.
//      After release, sequence restarts at 3499211612.
//   6. Pull rst low asynchronously mid-stream -> outputs 0 immediately.
//      After release with enable=0, sequence restarts at 3499211612.

Source files
------------

// File: rtl/mt_fsm.sv
// MT19937 (32-bit Mersenne Twister) pseudo-random number generator.
// An FSM loads a seed, fills the 624-word state one word per clock, and then
// twists one state word per clock in place. Each twisted word is tempered and
// presented on random_number with valid_rn, so the output runs at one word per
// clock with no gap across the 624-word wrap. The output is bit-exact with the
// reference genrand_int32 sequence for the same seed.
module mt_fsm #(
  parameter logic [31:0] DEFAULT_SEED = 32'd5489
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        external_seed_enable,
  input  logic [31:0] external_seed_value,
  output logic [31:0] random_number,
  output logic        valid_rn
);

  localparam int          N_WORDS  = 624;
  localparam logic [9:0]  LAST_IDX = 10'd623;
  // (i + 397) mod 624 wraps once i reaches 624 - 397 = 227.
  localparam logic [9:0]  FAR_WRAP = 10'd227;
  localparam logic [9:0]  FAR_OFS  = 10'd397;
  localparam logic [31:0] MATRIX_A = 32'h9908B0DF;
  localparam logic [31:0] INIT_MUL = 32'd1812433253;

  typedef enum logic [1:0] {
    LOAD,
    INIT,
    TWIST
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] seed_q, seed_d;
  logic [9:0]  idx_q, idx_d;
  logic [31:0] last_q, last_d;       // previous word written during INIT
  logic [31:0] number_d;
  logic        valid_d;

  logic [31:0] mt [N_WORDS];
  logic        mem_we;
  logic [31:0] mem_wdata;

  logic [9:0]  idx_next;
  logic [9:0]  idx_far;
  logic [31:0] word_cur, word_next, word_far;
  logic [31:0] twist_y;
  logic [31:0] twist_word;
  logic [31:0] init_mix;
  logic [31:0] init_word;

  // Tempering transform applied to each freshly twisted state word.
  function automatic logic [31:0] temper(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    t = t ^ (t >> 11);
    t = t ^ ((t << 7) & 32'h9D2C5680);
    t = t ^ ((t << 15) & 32'hEFC60000);
    t = t ^ (t >> 18);
    return t;
  endfunction

  // Index arithmetic and the three state reads needed by one twist step.
  always_comb begin
    idx_next   = (idx_q == LAST_IDX) ? 10'd0 : idx_q + 10'd1;
    idx_far    = (idx_q >= FAR_WRAP) ? idx_q - FAR_WRAP : idx_q + FAR_OFS;
    word_cur   = mt[idx_q];
    word_next  = mt[idx_next];
    word_far   = mt[idx_far];
    // Top bit of mt[i] joined with the low 31 bits of mt[i+1].
    twist_y    = {word_cur[31], word_next[30:0]};
    twist_word = word_far ^ (twist_y >> 1) ^ (twist_y[0] ? MATRIX_A : 32'd0);
    init_mix   = last_q ^ (last_q >> 30);
    init_word  = (idx_q == 10'd0) ? seed_q
                                  : (INIT_MUL * init_mix) + {22'd0, idx_q};
  end

  // Next-state logic: sequencing, state-store write port and output staging.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    idx_d     = idx_q;
    last_d    = last_q;
    number_d  = random_number;
    valid_d   = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = twist_word;

    case (state_q)
      LOAD: begin
        if (external_seed_enable) begin
          seed_d = external_seed_value;
        end else begin
          state_d = INIT;
          idx_d   = 10'd0;
        end
      end

      INIT: begin
        if (external_seed_enable) begin
          // Abort: new seed captured, full re-initialisation on release.
          state_d = LOAD;
          seed_d  = external_seed_value;
          idx_d   = 10'd0;
        end else begin
          mem_we    = 1'b1;
          mem_wdata = init_word;
          last_d    = init_word;
          if (idx_q == LAST_IDX) begin
            state_d = TWIST;
            idx_d   = 10'd0;
          end else begin
            idx_d = idx_q + 10'd1;
          end
        end
      end

      TWIST: begin
        if (external_seed_enable) begin
          state_d = LOAD;
          seed_d  = external_seed_value;
          idx_d   = 10'd0;
        end else begin
          mem_we    = 1'b1;
          mem_wdata = twist_word;
          number_d  = temper(twist_word);
          valid_d   = 1'b1;
          idx_d     = idx_next;
        end
      end

      default: begin
        state_d = LOAD;
        idx_d   = 10'd0;
      end
    endcase
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Seed, index and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seed_q        <= DEFAULT_SEED;
      idx_q         <= 10'd0;
      last_q        <= 32'd0;
      random_number <= 32'd0;
      valid_rn      <= 1'b0;
    end else begin
      seed_q        <= seed_d;
      idx_q         <= idx_d;
      last_q        <= last_d;
      random_number <= number_d;
      valid_rn      <= valid_d;
    end
  end

  // State store write port.
  // NOTE: the array is deliberately not reset; INIT rewrites all 624 words
  // before any of them is read, so a reset would only cost logic.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mt[idx_q] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_mt_fsm.sv
// Self-checking bench for mt_fsm: known-answer vectors, latency, abort and
// asynchronous-reset sequences, plus random seeds compared against a
// block-generate software model of MT19937.
module tb_mt_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        external_seed_enable;
  logic [31:0] external_seed_value;
  logic [31:0] random_number;
  logic        valid_rn;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mt_fsm dut (
    .clk                 (clk),
    .rst                 (rst),
    .external_seed_enable(external_seed_enable),
    .external_seed_value (external_seed_value),
    .random_number       (random_number),
    .valid_rn            (valid_rn)
  );

  // ---------------- reference model (classic block-generate MT19937) -------
  logic [31:0] ref_mt [624];
  int          ref_mti;

  function automatic void ref_seed(input logic [31:0] s);
    ref_mt[0] = s;
    for (int k = 1; k < 624; k++)
      ref_mt[k] = 32'd1812433253 * (ref_mt[k-1] ^ (ref_mt[k-1] >> 30)) + 32'(k);
    ref_mti = 624;
  endfunction

  function automatic logic [31:0] ref_mix(input logic [31:0] hi, input logic [31:0] lo,
                                          input logic [31:0] far);
    logic [31:0] y;
    y = (hi & 32'h80000000) | (lo & 32'h7FFFFFFF);
    return far ^ (y >> 1) ^ (y[0] ? 32'h9908B0DF : 32'd0);
  endfunction

  function automatic logic [31:0] ref_next();
    logic [31:0] y;
    if (ref_mti >= 624) begin
      for (int k = 0; k < 227; k++)
        ref_mt[k] = ref_mix(ref_mt[k], ref_mt[k+1], ref_mt[k+397]);
      for (int k = 227; k < 623; k++)
        ref_mt[k] = ref_mix(ref_mt[k], ref_mt[k+1], ref_mt[k-227]);
      ref_mt[623] = ref_mix(ref_mt[623], ref_mt[0], ref_mt[396]);
      ref_mti = 0;
    end
    y = ref_mt[ref_mti];
    ref_mti++;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9D2C5680);
    y = y ^ ((y << 15) & 32'hEFC60000);
    y = y ^ (y >> 18);
    return y;
  endfunction

  // ---------------- helpers ------------------------------------------------
  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d)",
               name, actual, actual, expected, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    external_seed_enable = 1'b0;
    external_seed_value  = 32'd0;
    step();
    rst = 1'b1;
  endtask

  // Counts edges until valid_rn rises (bounded); held=0 if random_number
  // moved before that.
  task automatic wait_first(output int edges, output bit held);
    logic [31:0] start_val;
    start_val = random_number;
    edges = 0;
    held  = 1'b1;
    for (int k = 0; k < 700; k++) begin
      if (valid_rn === 1'b1) break;
      step();
      edges++;
      if (valid_rn !== 1'b1 && random_number !== start_val) held = 1'b0;
    end
    if (valid_rn !== 1'b1) check("first valid timeout", {31'd0, valid_rn}, 32'd1);
  endtask

  // Reset, optionally load an external seed for two cycles, leave LOAD and
  // wait for the first valid word.
  task automatic start_stream(input bit use_ext, input logic [31:0] seed,
                              output int edges, output bit held);
    apply_reset();
    if (use_ext) begin
      external_seed_enable = 1'b1;
      external_seed_value  = seed;
      step();
      step();
      external_seed_enable = 1'b0;
      external_seed_value  = 32'd0;
    end
    step();  // LOAD exits on this edge
    wait_first(edges, held);
  endtask

  task automatic advance(input int n, output bit gapless);
    gapless = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      if (valid_rn !== 1'b1) gapless = 1'b0;
    end
  endtask

  task automatic compare_stream(input string name, input bit use_ext,
                                input logic [31:0] seed, input int n_words);
    int          edges;
    bit          held;
    bit          gapless;
    int          mism;
    logic [31:0] want;
    start_stream(use_ext, seed, edges, held);
    ref_seed(seed);
    mism    = 0;
    gapless = 1'b1;
    for (int k = 0; k < n_words; k++) begin
      if (k > 0) begin
        step();
        if (valid_rn !== 1'b1) gapless = 1'b0;
      end
      want = ref_next();
      if (random_number !== want) mism++;
    end
    check({name, " word mismatches"}, 32'(mism), 32'd0);
    check({name, " valid gapless"}, {31'd0, gapless}, 32'd1);
  endtask

  // ---------------- known-answer vector table ------------------------------
  typedef struct {
    bit          use_ext;
    logic [31:0] seed;
    int          idx;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          edges;
    bit          held;
    bit          gapless;
    logic [31:0] want;
    logic [31:0] seed2;

    vecs[0] = '{1'b0, 32'd5489, 0,    32'd3499211612};
    vecs[1] = '{1'b0, 32'd5489, 1,    32'd581869302};
    vecs[2] = '{1'b0, 32'd5489, 2,    32'd3890346734};
    vecs[3] = '{1'b0, 32'd5489, 9999, 32'd4123659995};
    vecs[4] = '{1'b1, 32'd5489, 1,    32'd581869302};

    rst = 1'b0;
    external_seed_enable = 1'b0;
    external_seed_value  = 32'd0;
    #12;
    check("reset random_number", random_number, 32'd0);
    check("reset valid_rn", {31'd0, valid_rn}, 32'd0);

    // Known answers, including the 10000th word across many wraps.
    for (int v = 0; v < 5; v++) begin
      start_stream(vecs[v].use_ext, vecs[v].seed, edges, held);
      advance(vecs[v].idx, gapless);
      check($sformatf("vec%0d word %0d", v, vecs[v].idx), random_number, vecs[v].expected);
      if (vecs[v].idx > 0)
        check($sformatf("vec%0d valid gapless", v), {31'd0, gapless}, 32'd1);
    end

    // Latency from LOAD exit, with outputs quiet until then.
    apply_reset();
    check("post-reset random_number", random_number, 32'd0);
    check("post-reset valid_rn", {31'd0, valid_rn}, 32'd0);
    step();
    wait_first(edges, held);
    check("latency edges", 32'(edges), 32'd625);
    check("random_number zero before valid", {31'd0, held}, 32'd1);
    check("latency first word", random_number, 32'd3499211612);

    // Model-checked streams: fixed seed and random seeds across wraps.
    compare_stream("seed feedbeef", 1'b1, 32'hFEEDBEEF, 2000);
    compare_stream("default seed", 1'b0, 32'd5489, 700);
    for (int r = 0; r < 3; r++)
      compare_stream($sformatf("random seed %0d", r), 1'b1, $urandom, 1300);

    // Abort mid-TWIST, then restart with 5489.
    start_stream(1'b0, 32'd5489, edges, held);
    advance(100, gapless);
    ref_seed(32'd5489);
    want = 32'd0;
    for (int k = 0; k <= 100; k++) want = ref_next();
    check("pre-abort word 100", random_number, want);
    external_seed_enable = 1'b1;
    external_seed_value  = 32'd5489;
    step();
    check("twist abort valid_rn", {31'd0, valid_rn}, 32'd0);
    check("twist abort holds word", random_number, want);
    external_seed_enable = 1'b0;
    step();
    wait_first(edges, held);
    check("twist abort restart latency", 32'(edges), 32'd625);
    check("twist abort restart word", random_number, 32'd3499211612);

    // Abort mid-INIT with a new seed; no partial state may survive.
    seed2 = 32'h1234ABCD;
    apply_reset();
    step();
    advance(300, gapless);
    check("init valid_rn low", {31'd0, valid_rn}, 32'd0);
    external_seed_enable = 1'b1;
    external_seed_value  = seed2;
    step();
    check("init abort valid_rn", {31'd0, valid_rn}, 32'd0);
    external_seed_enable = 1'b0;
    external_seed_value  = 32'd0;
    step();
    wait_first(edges, held);
    check("init abort restart latency", 32'(edges), 32'd625);
    ref_seed(seed2);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      check($sformatf("init abort word %0d", k), random_number, ref_next());
    end

    // Asynchronous reset between clock edges mid-stream.
    start_stream(1'b0, 32'd5489, edges, held);
    advance(50, gapless);
    #2;
    rst = 1'b0;
    #1;
    check("async reset random_number", random_number, 32'd0);
    check("async reset valid_rn", {31'd0, valid_rn}, 32'd0);
    step();
    rst = 1'b1;
    external_seed_enable = 1'b0;
    step();
    wait_first(edges, held);
    check("async reset restart latency", 32'(edges), 32'd625);
    check("async reset restart word", random_number, 32'd3499211612);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
